// File: rtl/skewed_operand_buffer.sv
// Double-banked operand buffer: row-major load into one bank while the other
// drains as a diagonally skewed wavefront (lane i lags lane i-1 by one cycle).
module skewed_operand_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int ELEMS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_start,
    output logic                        rd_busy,
    output logic                        rd_done,
    output logic [1:0]                  banks_full,
    output logic [LINES-1:0]            out_valid,
    output logic [DATA_WIDTH*LINES-1:0] data_out
);

    localparam int DEPTH     = LINES * ELEMS;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int ADDR_W    = $clog2(2 * DEPTH);
    localparam int LAST_STEP = ELEMS + LINES - 2;
    localparam int STEP_W    = $clog2(LAST_STEP + 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
    typedef enum logic {D_IDLE, D_DRAIN} drain_state_t;

    bank_state_t                bank_state [2];
    drain_state_t               drain_state, drain_next;
    logic                       wr_bank, rd_bank;
    logic [PTR_W-1:0]           wr_ptr;
    logic [STEP_W-1:0]          step;
    logic [DATA_WIDTH-1:0]      mem [2*DEPTH];

    logic                       wr_fire, wr_last, rd_accept, last_step, load_out;
    logic [ADDR_W-1:0]          wr_addr;
    int                         next_step;
    logic [LINES-1:0]           nxt_valid;
    logic [DATA_WIDTH*LINES-1:0] nxt_data;

    assign wr_ready  = !rst && (bank_state[wr_bank] == B_EMPTY || bank_state[wr_bank] == B_FILLING);
    assign wr_fire   = wr_valid && wr_ready;
    assign wr_last   = (wr_ptr == PTR_W'(DEPTH - 1));
    assign wr_addr   = ADDR_W'(int'(wr_bank) * DEPTH + int'(wr_ptr));
    assign rd_busy   = (drain_state == D_DRAIN);
    assign last_step = rd_busy && (step == STEP_W'(LAST_STEP));
    assign rd_done   = last_step;
    assign rd_accept = (drain_state == D_IDLE) && rd_start && (banks_full != 2'd0);
    assign load_out  = rd_accept || (rd_busy && !last_step);

    // DRAINING banks are deliberately excluded from the count.
    always_comb begin
        banks_full = 2'd0;
        for (int b = 0; b < 2; b++) begin
            if (bank_state[b] == B_FULL) banks_full = banks_full + 2'd1;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        drain_next = drain_state;
        case (drain_state)
            D_IDLE:  if (rd_accept) drain_next = D_DRAIN;
            D_DRAIN: if (last_step) drain_next = D_IDLE;
            default: drain_next = D_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) drain_state <= D_IDLE;
        else     drain_state <= drain_next;
    end

    // Wavefront for the step about to be shown: step 0 on accept, else s+1.
    always_comb begin
        next_step = (drain_state == D_IDLE) ? 0 : int'(step) + 1;
        nxt_valid = '0;
        nxt_data  = '0;
        for (int i = 0; i < LINES; i++) begin
            if (next_step >= i && next_step - i < ELEMS) begin
                nxt_valid[i] = 1'b1;
                nxt_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem[ADDR_W'(int'(rd_bank) * DEPTH + i * ELEMS + next_step - i)];
            end
        end
    end

    // NOTE: the memory array has no reset; out_valid masks any stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) bank_state[b] <= B_EMPTY;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= '0;
            step      <= '0;
            out_valid <= '0;
            data_out  <= '0;
        end else begin
            if (wr_fire) begin
                bank_state[wr_bank] <= wr_last ? B_FULL : B_FILLING;
                wr_ptr              <= wr_last ? '0 : wr_ptr + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end

            if (rd_accept) begin
                bank_state[rd_bank] <= B_DRAINING;
                step                <= '0;
            end else if (rd_busy) begin
                step <= last_step ? '0 : step + 1'b1;
            end

            if (last_step) begin
                bank_state[rd_bank] <= B_EMPTY;
                rd_bank             <= ~rd_bank;
            end

            if (load_out) begin
                out_valid <= nxt_valid;
                data_out  <= nxt_data;
            end else begin
                out_valid <= '0;
                data_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skewed_operand_buffer.sv
// Self-checking bench: tile-level reference model for the default build plus
// directed checks on a 16-bit, 2-lane, 8-element instance.
module tb_skewed_operand_buffer;

    localparam int DW    = 8;
    localparam int L     = 4;
    localparam int E     = 4;
    localparam int DEPTH = L * E;
    localparam int LAST  = E + L - 2;

    localparam int DW2   = 16;
    localparam int L2    = 2;
    localparam int E2    = 8;
    localparam int LAST2 = E2 + L2 - 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, wr_valid, wr_ready, rd_start, rd_busy, rd_done;
    logic [DW-1:0]    wr_data;
    logic [1:0]       banks_full;
    logic [L-1:0]     out_valid;
    logic [DW*L-1:0]  data_out;

    logic              b_rst, b_wr_valid, b_wr_ready, b_rd_start, b_rd_busy, b_rd_done;
    logic [DW2-1:0]    b_wr_data;
    logic [1:0]        b_banks_full;
    logic [L2-1:0]     b_out_valid;
    logic [DW2*L2-1:0] b_data_out;

    skewed_operand_buffer #(.DATA_WIDTH(DW), .LINES(L), .ELEMS(E)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_done(rd_done), .banks_full(banks_full),
        .out_valid(out_valid), .data_out(data_out)
    );

    skewed_operand_buffer #(.DATA_WIDTH(DW2), .LINES(L2), .ELEMS(E2)) dut_b (
        .clk(clk), .rst(b_rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_start(b_rd_start), .rd_busy(b_rd_busy), .rd_done(b_rd_done), .banks_full(b_banks_full),
        .out_valid(b_out_valid), .data_out(b_data_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tiles are either filling, waiting (FIFO), or draining.
    logic [DW-1:0] fill_buf [$];
    logic [DW-1:0] full_words [$];
    logic [DW-1:0] drain_tile [DEPTH];
    int            n_full = 0;
    bit            m_busy = 1'b0;
    int            m_step = 0;

    always @(posedge clk) begin : model
        bit acc_wr, acc_rd, fin;
        if (rst) begin
            fill_buf.delete();
            full_words.delete();
            n_full = 0;
            m_busy = 1'b0;
            m_step = 0;
        end else begin
            acc_wr = wr_valid && (n_full + int'(m_busy) < 2);
            acc_rd = rd_start && !m_busy && n_full > 0;
            fin    = m_busy && m_step == LAST;
            if (fin)         m_busy = 1'b0;
            else if (m_busy) m_step++;
            if (acc_rd) begin
                for (int k = 0; k < DEPTH; k++) drain_tile[k] = full_words.pop_front();
                n_full--;
                m_busy = 1'b1;
                m_step = 0;
            end
            if (acc_wr) begin
                fill_buf.push_back(wr_data);
                if (fill_buf.size() == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) full_words.push_back(fill_buf.pop_front());
                    n_full++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [L-1:0]    ev;
        logic [DW*L-1:0] ed;
        if (started) begin
            ev = '0;
            ed = '0;
            if (m_busy) begin
                for (int i = 0; i < L; i++) begin
                    if (m_step >= i && m_step - i < E) begin
                        ev[i] = 1'b1;
                        ed[i*DW +: DW] = drain_tile[i*E + m_step - i];
                    end
                end
            end
            check("wr_ready",   wr_ready,   !rst && (n_full + int'(m_busy) < 2));
            check("rd_busy",    rd_busy,    m_busy);
            check("rd_done",    rd_done,    m_busy && m_step == LAST);
            check("banks_full", banks_full, n_full);
            check("out_valid",  out_valid,  ev);
            check("data_out",   data_out,   ed);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bit acc;
        acc = 1'b0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int g = 0; g < 60; g++) begin
            acc = wr_ready;
            tick();
            if (acc) break;
        end
        check("wr_accept", acc, 1'b1);
        wr_valid = 1'b0;
    endtask

    task automatic load_tile(input bit rnd, input logic [DW-1:0] base, input bit gaps);
        for (int k = 0; k < DEPTH; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            write_word(rnd ? DW'($urandom) : base + DW'(k));
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 60; c++) begin
            if (rd_done) break;
            tick();
        end
        check("rd_done_seen", rd_done, 1'b1);
    endtask

    task automatic drain();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        wait_done();
        tick();
    endtask

    logic [3:0] walk [7];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        walk = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_start = 1'b0;
        b_rst = 1'b1; b_wr_valid = 1'b0; b_wr_data = '0; b_rd_start = 1'b0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0; b_rst = 1'b0;
        #1;
        check("init_wr_ready", wr_ready, 1'b1);

        // Reset held two cycles in the middle of a fill.
        for (int k = 0; k < 5; k++) write_word(DW'(8'hA0 + k));
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", rd_busy, 1'b0);
        check("rst_banks_full", banks_full, 2'd0);
        check("rst_out_valid", out_valid, '0);
        check("rst_data_out", data_out, '0);
        rst = 1'b0;
        #1;
        check("rst_wr_ready_after", wr_ready, 1'b1);

        // Single tile 0x01..0x10, hand-computed wavefront.
        load_tile(1'b0, 8'h01, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("tile_lane0_first", data_out[7:0], 8'h01);
        for (int s = 0; s <= LAST; s++) begin
            check("tile_walk", out_valid, walk[s]);
            check("tile_done", rd_done, s == LAST);
            if (s == 3) check("tile_lane3_first", data_out[31:24], 8'h0D);
            tick();
        end
        check("tile_busy_after", rd_busy, 1'b0);

        // Back-pressure: 33 words with wr_valid held high.
        for (int k = 0; k < 32; k++) write_word(DW'(k + 1));
        wr_valid = 1'b1;
        wr_data  = 8'hAB;
        check("bp_banks_full", banks_full, 2'd2);
        check("bp_ready_low", wr_ready, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        wait_done();
        check("bp_ready_at_done", wr_ready, 1'b0);
        tick();
        check("bp_ready_after_done", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Ignored starts: empty buffer, mid-drain, same cycle as last fill word.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("ign_empty_busy", rd_busy, 1'b0);
        load_tile(1'b1, '0, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        check("ign_mid_no_done_t6", rd_done, 1'b0);
        tick();
        check("ign_mid_done_t7", rd_done, 1'b1);
        tick();
        check("ign_mid_idle_t8", rd_busy, 1'b0);
        for (int k = 0; k < DEPTH - 1; k++) write_word(DW'($urandom));
        check("ign_last_ready", wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_data  = DW'($urandom);
        rd_start = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_start = 1'b0;
        check("ign_last_busy", rd_busy, 1'b0);
        check("ign_last_full", banks_full, 2'd1);

        // Ping-pong overlap: drain A while filling B with gaps, then drain B.
        fork
            drain();
            load_tile(1'b1, '0, 1'b1);
        join
        drain();

        // Reset at T+3 of a drain, then reload and drain.
        load_tile(1'b1, '0, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", rd_busy, 1'b0);
        check("mid_rst_done", rd_done, 1'b0);
        check("mid_rst_valid", out_valid, '0);
        check("mid_rst_data", data_out, '0);
        check("mid_rst_full", banks_full, 2'd0);
        rst = 1'b0;
        load_tile(1'b1, '0, 1'b1);
        drain();

        // Second geometry: 16-bit, 2 lanes x 8 elements.
        b_wr_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b_wr_data = DW2'(16'h0100 + k);
            check("b_wr_ready", b_wr_ready, 1'b1);
            tick();
        end
        b_wr_valid = 1'b0;
        b_rd_start = 1'b1;
        tick();
        b_rd_start = 1'b0;
        for (int s = 0; s <= LAST2; s++) begin
            for (int i = 0; i < L2; i++) begin
                if (s - i >= 0 && s - i < E2) begin
                    check("b_lane_valid", b_out_valid[i], 1'b1);
                    check("b_lane_data", b_data_out[i*DW2 +: DW2], 16'h0100 + i*E2 + s - i);
                end else begin
                    check("b_lane_idle", {b_out_valid[i], b_data_out[i*DW2 +: DW2]}, 17'h0);
                end
            end
            check("b_done", b_rd_done, s == LAST2);
            if (s == LAST2) check("b_lane1_last", b_data_out[31:16], 16'h010F);
            tick();
        end
        check("b_busy_after", b_rd_busy, 1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
